// File: rtl/conv_layer_sched_if.sv
// Handshake/bus bundle between the layer sequencer, conv_layer_sched and the pass controller.
// master = environment side (sequencer + pass controller), slave = the scheduler itself.
interface conv_layer_sched_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] img_base;
    logic [ADDR_W-1:0] kernel_base;
    logic [ADDR_W-1:0] result_base;
    logic              completed;
    logic              en_conv2d;
    logic [ADDR_W-1:0] pix_base_addr;
    logic [ADDR_W-1:0] kernel_base_addr;
    logic [ADDR_W-1:0] base_result_addr;
    logic              accumulate;
    logic [7:0]        filter_idx;
    logic [7:0]        chan_idx;
    logic              busy;
    logic              layer_done;
    logic              timeout_err;

    modport master (
        output start, abort, img_base, kernel_base, result_base, completed,
        input  en_conv2d, pix_base_addr, kernel_base_addr, base_result_addr, accumulate,
               filter_idx, chan_idx, busy, layer_done, timeout_err
    );

    modport slave (
        input  start, abort, img_base, kernel_base, result_base, completed,
        output en_conv2d, pix_base_addr, kernel_base_addr, base_result_addr, accumulate,
               filter_idx, chan_idx, busy, layer_done, timeout_err
    );
endinterface

// File: rtl/conv_layer_sched.sv
// Convolution layer scheduler: walks (filter, channel) passes and drives the pass controller.
// Optional per-pass watchdog enabled by defining SCHED_TIMEOUT_EN.
module conv_layer_sched #(
    parameter int unsigned IMG_WIDTH      = 48,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned NUM_FILTERS    = 8,
    parameter int unsigned NUM_CHANNELS   = 3,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst,
    conv_layer_sched_if.slave bus
);
    localparam int unsigned OutW = IMG_WIDTH - KERNEL_SIZE + 1;

    localparam logic [ADDR_W-1:0] PlaneInc  = ADDR_W'(IMG_WIDTH * IMG_WIDTH);
    localparam logic [ADDR_W-1:0] KareaInc  = ADDR_W'(KERNEL_SIZE * KERNEL_SIZE);
    localparam logic [ADDR_W-1:0] OplaneInc = ADDR_W'(OutW * OutW);
    localparam logic [7:0]        LastF     = 8'(NUM_FILTERS - 1);
    localparam logic [7:0]        LastC     = 8'(NUM_CHANNELS - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StRun  = 3'd2;
    localparam logic [2:0] StGap  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    if (NUM_FILTERS < 1 || NUM_FILTERS > 256 || NUM_CHANNELS < 1 || NUM_CHANNELS > 256 ||
        TIMEOUT_CYCLES < 1 || KERNEL_SIZE > IMG_WIDTH) begin : g_param_check
        $error("conv_layer_sched: illegal parameter combination");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] img_q, pix_q, kern_q, res_q;
    logic [7:0]        f_q, c_q;
    logic              last_pass;
    logic              accept_start;
    logic              timeout_hit;

    assign last_pass    = (f_q == LastF) && (c_q == LastC);
    assign accept_start = (state_q == StIdle) && bus.start;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StLoad;
            StLoad: state_d = StRun;
            StRun: begin
                if (bus.completed)  state_d = StGap;
                else if (timeout_hit) state_d = StIdle;
            end
            StGap:  state_d = last_pass ? StDone : StLoad;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort beats everything, including a coincident completed.
        if (bus.abort && (state_q != StIdle)) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Incremental address generation; the channel wrap reloads the pixel plane base.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_q  <= '0;
            pix_q  <= '0;
            kern_q <= '0;
            res_q  <= '0;
            f_q    <= '0;
            c_q    <= '0;
        end else if (accept_start) begin
            img_q  <= bus.img_base;
            pix_q  <= bus.img_base;
            kern_q <= bus.kernel_base;
            res_q  <= bus.result_base;
            f_q    <= '0;
            c_q    <= '0;
        end else if ((state_q == StGap) && !bus.abort && !last_pass) begin
            kern_q <= kern_q + KareaInc;
            if (c_q == LastC) begin
                c_q   <= '0;
                f_q   <= f_q + 8'd1;
                pix_q <= img_q;
                res_q <= res_q + OplaneInc;
            end else begin
                c_q   <= c_q + 8'd1;
                pix_q <= pix_q + PlaneInc;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            terr_q;

    assign timeout_hit = (state_q == StRun) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            if (state_q == StLoad)     cnt_q <= '0;
            else if (state_q == StRun) cnt_q <= cnt_q + 1'b1;
            if (accept_start) terr_q <= 1'b0;
            else if (timeout_hit && !bus.completed && !bus.abort) terr_q <= 1'b1;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.en_conv2d        = (state_q == StRun);
    assign bus.busy             = (state_q != StIdle);
    assign bus.layer_done       = (state_q == StDone);
    assign bus.pix_base_addr    = pix_q;
    assign bus.kernel_base_addr = kern_q;
    assign bus.base_result_addr = res_q;
    assign bus.accumulate       = (c_q != 8'd0);
    assign bus.filter_idx       = f_q;
    assign bus.chan_idx         = c_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: scoreboard of expected passes, immediate-assertion checks.
module tb_conv_layer_sched;
    localparam int unsigned IW = 48;
    localparam int unsigned KS = 3;
    localparam int unsigned NF = 8;
    localparam int unsigned NC = 3;
    localparam int unsigned AW = 14;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [AW-1:0] pix;
        logic [AW-1:0] kern;
        logic [AW-1:0] res;
        logic          acc;
        logic [7:0]    f;
        logic [7:0]    c;
    } pass_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ld_cnt = 0;
    pass_t sb[$];

    conv_layer_sched_if #(.ADDR_W(AW)) bus ();

    conv_layer_sched #(
        .IMG_WIDTH     (IW),
        .KERNEL_SIZE   (KS),
        .NUM_FILTERS   (NF),
        .NUM_CHANNELS  (NC),
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.layer_done === 1'b1) ld_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected passes straight from the closed-form address formulas.
    task automatic push_layer(input logic [AW-1:0] ib, input logic [AW-1:0] kb,
                              input logic [AW-1:0] rb);
        pass_t p;
        int unsigned plane = IW * IW;
        int unsigned karea = KS * KS;
        int unsigned oplane = (IW - KS + 1) * (IW - KS + 1);
        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < NC; c++) begin
                p.pix  = AW'(ib + c * plane);
                p.kern = AW'(kb + (f * NC + c) * karea);
                p.res  = AW'(rb + f * oplane);
                p.acc  = (c != 0);
                p.f    = 8'(f);
                p.c    = 8'(c);
                sb.push_back(p);
            end
        end
    endtask

    task automatic start_layer(input logic [AW-1:0] ib, input logic [AW-1:0] kb,
                               input logic [AW-1:0] rb);
        @(negedge clk);
        bus.img_base    = ib;
        bus.kernel_base = kb;
        bus.result_base = rb;
        bus.start       = 1'b1;
        push_layer(ib, kb, rb);
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_en", bus.en_conv2d, 0);
    endtask

    task automatic wait_en(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (bus.en_conv2d === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("en_rise", ok, 1);
    endtask

    task automatic check_pass(input pass_t e);
        chk("pix", bus.pix_base_addr, e.pix);
        chk("kern", bus.kernel_base_addr, e.kern);
        chk("res", bus.base_result_addr, e.res);
        chk("acc", bus.accumulate, e.acc);
        chk("fidx", bus.filter_idx, e.f);
        chk("cidx", bus.chan_idx, e.c);
    endtask

    task automatic do_pass(input bit last);
        bit    ok;
        bit    stable;
        int    n;
        pass_t e;
        wait_en(ok, n);
        if (!ok) return;
        chk("en_latency", n, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check_pass(e);
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.en_conv2d !== 1'b1 || bus.pix_base_addr !== e.pix ||
                bus.kernel_base_addr !== e.kern || bus.base_result_addr !== e.res)
                stable = 1'b0;
        end
        chk("addr_stable", stable, 1);
        bus.completed = 1'b1;
        @(negedge clk);
        bus.completed = 1'b0;
        chk("gap_en", bus.en_conv2d, 0);
        chk("gap_busy", bus.busy, 1);
        @(negedge clk);
        if (last) begin
            chk("done_pulse", bus.layer_done, 1);
            @(negedge clk);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.layer_done, 0);
        end else begin
            chk("load_en", bus.en_conv2d, 0);
            chk("load_done", bus.layer_done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"}, bus.en_conv2d, 0);
        chk({tag, "_pix"}, bus.pix_base_addr, 0);
        chk({tag, "_kern"}, bus.kernel_base_addr, 0);
        chk({tag, "_res"}, bus.base_result_addr, 0);
        chk({tag, "_acc"}, bus.accumulate, 0);
        chk({tag, "_fidx"}, bus.filter_idx, 0);
        chk({tag, "_cidx"}, bus.chan_idx, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.layer_done, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
    endtask

    initial begin
        bit ok;
        int n;
        bit held;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.completed   = 1'b0;
        bus.img_base    = '0;
        bus.kernel_base = '0;
        bus.result_base = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Stray completed in IDLE must not move the FSM.
        @(negedge clk);
        bus.completed = 1'b1;
        @(negedge clk);
        bus.completed = 1'b0;
        chk("stray_busy", bus.busy, 0);
        chk("stray_en", bus.en_conv2d, 0);
        @(negedge clk);
        chk("stray_busy2", bus.busy, 0);

        // Full layer, 24 passes.
        start_layer(14'h0000, 14'h3000, 14'h1000);
        for (int i = 0; i < NF * NC; i++) do_pass(i == NF * NC - 1);
        chk("layer_done_count", ld_cnt, 1);
        chk("sb_drained", sb.size(), 0);

        // Result base wraps modulo 2^14 for filter 1; abort + completed together at (f1,c0).
        start_layer(14'h0100, 14'h0000, 14'h3FF0);
        for (int i = 0; i < NC; i++) do_pass(1'b0);
        wait_en(ok, n);
        chk("wrap_res", bus.base_result_addr, 14'h0834);
        chk("wrap_f", bus.filter_idx, 1);
        chk("wrap_c", bus.chan_idx, 0);
        chk("wrap_pix", bus.pix_base_addr, 14'h0100);
        chk("wrap_acc", bus.accumulate, 0);
        bus.abort     = 1'b1;
        bus.completed = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.completed = 1'b0;
        chk("abort_en", bus.en_conv2d, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.layer_done, 0);
        chk("abort_fidx_kept", bus.filter_idx, 1);
        chk("abort_res_kept", bus.base_result_addr, 14'h0834);
        @(negedge clk);
        chk("abort_idle", bus.busy, 0);
        chk("abort_no_done", ld_cnt, 1);
        sb.delete();

        // Restart begins again at (f0,c0).
        start_layer(14'h0000, 14'h3000, 14'h1000);
        do_pass(1'b0);
        wait_en(ok, n);
`ifdef SCHED_TIMEOUT_EN
        held = 1'b1;
        repeat (TO - 1) begin
            @(negedge clk);
            if (bus.en_conv2d !== 1'b1) held = 1'b0;
        end
        chk("to_held", held, 1);
        @(negedge clk);
        chk("to_en", bus.en_conv2d, 0);
        chk("to_err", bus.timeout_err, 1);
        chk("to_busy", bus.busy, 0);
        chk("to_no_done", ld_cnt, 1);
        sb.delete();
        start_layer(14'h0000, 14'h3000, 14'h1000);
        chk("to_err_cleared", bus.timeout_err, 0);
        wait_en(ok, n);
`else
        held = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.en_conv2d !== 1'b1 || bus.timeout_err !== 1'b0) held = 1'b0;
        end
        chk("no_watchdog_hold", held, 1);
        chk("no_watchdog_err", bus.timeout_err, 0);
`endif

        // Reset in the middle of RUN.
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
